viterbi_acs_unit: RTL and testbench



---
 rtl/viterbi_pkg.sv | 17 +
 rtl/viterbi_acs_unit_if.sv | 20 ++
 rtl/viterbi_bmu.sv | 15 +
 rtl/viterbi_acs_unit.sv | 115 +++++++++++
 tb/tb_viterbi_acs_unit.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/viterbi_pkg.sv
// viterbi_pkg: shared parameters, types and encoder helper for the rate-1/2 Viterbi ACS slice
package viterbi_pkg;
    localparam int K = 3;
    localparam int NSTATES = 1 << (K - 1);
    localparam logic [K-1:0] G0 = 3'b111;
    localparam logic [K-1:0] G1 = 3'b101;
    localparam int PM_W = 8;
    typedef logic [PM_W-1:0] pm_t;
    typedef logic [K-2:0] state_t;
    typedef enum logic {IDLE, RUN} acs_state_e;
    // Encoder output {out[1], out[0]} when input bit b is shifted into state p
    function automatic logic [1:0] expected_sym(state_t p, logic b);
        logic [K-1:0] r;
        r = {b, p};
        return {^(G0 & r), ^(G1 & r)};
    endfunction
endpackage

// File: rtl/viterbi_acs_unit_if.sv
// viterbi_acs_unit_if: symbol-in / decision-out handshake bundle
//   master: symbol source + decision sink (drives rx_*, dec_ready)
//   slave : the ACS unit (drives rx_ready, dec_*, decisions, best_*)
interface viterbi_acs_unit_if;
    import viterbi_pkg::*;
    logic rx_valid, rx_ready, rx_sof, rx_eof;
    logic [1:0] rx_sym;
    logic dec_valid, dec_ready, dec_eof;
    logic [NSTATES-1:0] decisions;
    state_t best_state;
    pm_t best_metric;
    modport master (
        output rx_valid, rx_sym, rx_sof, rx_eof, dec_ready,
        input  rx_ready, dec_valid, decisions, best_state, best_metric, dec_eof
    );
    modport slave (
        input  rx_valid, rx_sym, rx_sof, rx_eof, dec_ready,
        output rx_ready, dec_valid, decisions, best_state, best_metric, dec_eof
    );
endinterface

// File: rtl/viterbi_bmu.sv
// viterbi_bmu: combinational Hamming branch metrics for every (predecessor, input bit) transition
//   rx_sym in  received hard bits {out[1], out[0]}
//   bm     out bm[p][b] = distance between rx_sym and the symbol expected on transition (p, b)
module viterbi_bmu
    import viterbi_pkg::*;
(
    input  logic [1:0] rx_sym,
    output logic [1:0] bm [NSTATES][2]
);
    for (genvar p = 0; p < NSTATES; p++) begin : g_p
        for (genvar b = 0; b < 2; b++) begin : g_b
            assign bm[p][b] = 2'($countones(rx_sym ^ expected_sym(state_t'(p), 1'(b))));
        end
    end
endmodule

// File: rtl/viterbi_acs_unit.sv
// viterbi_acs_unit: add-compare-select stage producing survivor decisions and best state per symbol
//   clk  in  clock
//   rst  in  asynchronous active-low reset
//   bus  slave handshake: rx_* symbols in, dec_* decision words out
//   busy out frame in progress
// Optional ACS_NORM_EN: subtract 2^(PM_W-1) from all metrics when all have MSB set;
// otherwise metrics saturate at 2^PM_W - 1.
module viterbi_acs_unit
    import viterbi_pkg::*;
(
    input  logic clk,
    input  logic rst,
    viterbi_acs_unit_if.slave bus,
    output logic busy
);
    logic [1:0] bm [NSTATES][2];
    pm_t pm_q [NSTATES];
    pm_t pm_d [NSTATES];
    pm_t prior [NSTATES];
    pm_t pm_new [NSTATES];
    logic [PM_W:0] acs_sum [NSTATES];
    logic [NSTATES-1:0] dec_new, decisions_q, decisions_d;
    acs_state_e fsm_q, fsm_d;
    logic dec_valid_q, dec_valid_d, dec_eof_q, dec_eof_d;
    state_t best_state_q, best_state_d, best_new;
    pm_t best_metric_q, best_metric_d, best_new_metric;
    logic accept, init;
`ifdef ACS_NORM_EN
    logic all_hi;
`endif

    viterbi_bmu u_bmu (.rx_sym(bus.rx_sym), .bm(bm));

    assign bus.rx_ready = !dec_valid_q || bus.dec_ready;
    assign accept = bus.rx_valid && bus.rx_ready;
    // A symbol arriving in IDLE starts a frame even without rx_sof
    assign init = fsm_q == IDLE || bus.rx_sof;

    // Predecessors of s are {s[K-3:0], 0/1}; the input bit that leads into s is s[K-2]
    for (genvar s = 0; s < NSTATES; s++) begin : g_acs
        localparam int P0 = (2 * s) % NSTATES;
        localparam int B = s / (NSTATES / 2);
        logic [PM_W:0] c0, c1;
        assign prior[s] = init ? pm_t'(s == 0 ? 0 : 1 << (PM_W - 2)) : pm_q[s];
        assign c0 = {1'b0, prior[P0]} + (PM_W+1)'(bm[P0][B]);
        assign c1 = {1'b0, prior[P0+1]} + (PM_W+1)'(bm[P0+1][B]);
        // Strict compare keeps the even predecessor on ties
        assign dec_new[s] = c1 < c0;
        assign acs_sum[s] = dec_new[s] ? c1 : c0;
    end

    always_comb begin
`ifdef ACS_NORM_EN
        all_hi = 1'b1;
        for (int i = 0; i < NSTATES; i++) all_hi = all_hi & |acs_sum[i][PM_W:PM_W-1];
        for (int i = 0; i < NSTATES; i++) pm_new[i] = pm_t'(acs_sum[i] - {1'b0, all_hi, {(PM_W-1){1'b0}}});
`else
        for (int i = 0; i < NSTATES; i++) pm_new[i] = acs_sum[i][PM_W] ? '1 : acs_sum[i][PM_W-1:0];
`endif
        best_new = '0;
        best_new_metric = pm_new[0];
        for (int i = 1; i < NSTATES; i++) begin
            if (pm_new[i] < best_new_metric) begin
                best_new = state_t'(i);
                best_new_metric = pm_new[i];
            end
        end
    end

    always_comb begin
        fsm_d = fsm_q;
        pm_d = pm_q;
        dec_valid_d = dec_valid_q && !bus.dec_ready;
        decisions_d = decisions_q;
        best_state_d = best_state_q;
        best_metric_d = best_metric_q;
        dec_eof_d = dec_eof_q;
        if (accept) begin
            fsm_d = bus.rx_eof ? IDLE : RUN;
            pm_d = pm_new;
            dec_valid_d = 1'b1;
            decisions_d = dec_new;
            best_state_d = best_new;
            best_metric_d = best_new_metric;
            dec_eof_d = bus.rx_eof;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm_q <= IDLE;
            pm_q <= '{default: '0};
            dec_valid_q <= 1'b0;
            decisions_q <= '0;
            best_state_q <= '0;
            best_metric_q <= '0;
            dec_eof_q <= 1'b0;
        end else begin
            fsm_q <= fsm_d;
            pm_q <= pm_d;
            dec_valid_q <= dec_valid_d;
            decisions_q <= decisions_d;
            best_state_q <= best_state_d;
            best_metric_q <= best_metric_d;
            dec_eof_q <= dec_eof_d;
        end
    end

    assign bus.dec_valid = dec_valid_q;
    assign bus.decisions = decisions_q;
    assign bus.best_state = best_state_q;
    assign bus.best_metric = best_metric_q;
    assign bus.dec_eof = dec_eof_q;
    assign busy = fsm_q == RUN;
endmodule

// File: tb/tb_viterbi_acs_unit.sv
// tb_viterbi_acs_unit: directed and random frames checked against a forward trellis reference model
module tb_viterbi_acs_unit;
    logic clk, rst, busy;
    viterbi_acs_unit_if bus();

    viterbi_acs_unit dut (.clk(clk), .rst(rst), .bus(bus), .busy(busy));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] dec;
        logic [1:0] st;
        logic [7:0] m;
        logic eof;
    } word_t;

    word_t exp_q[$];
    int ref_pm[4];
    bit ref_run;
    int n_checks, n_pass, n_words;
    bit acc, rnd_ready;
    logic [3:0] last_dec, snap_dec;
    logic [1:0] last_state, snap_state;
    logic [7:0] last_metric, snap_metric;
    logic last_eof;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] expv);
        n_checks++;
        assert (got === expv) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, got, expv);
    endtask

    // Trellis step: state = {newest bit, older bit}; encoder taps 7/5 octal
    task automatic model_push(logic [1:0] sym, logic sof, logic eof);
        int nxt[4];
        int best;
        word_t w;
        w = '0;
        if (!ref_run || sof) ref_pm = '{0, 64, 64, 64};
        for (int i = 0; i < 4; i++) nxt[i] = 1 << 30;
        for (int p = 0; p < 4; p++) begin
            for (int b = 0; b < 2; b++) begin
                int s1 = p >> 1;
                int s0 = p & 1;
                int e1 = b ^ s1 ^ s0;
                int e0 = b ^ s0;
                int r1 = int'(sym[1]);
                int r0 = int'(sym[0]);
                int ns = (b << 1) | s1;
                int c = ref_pm[p] + int'(r1 != e1) + int'(r0 != e0);
                if (c < nxt[ns]) begin
                    nxt[ns] = c;
                    w.dec[ns] = 1'(p & 1);
                end
            end
        end
`ifdef ACS_NORM_EN
        if (nxt[0] >= 128 && nxt[1] >= 128 && nxt[2] >= 128 && nxt[3] >= 128)
            for (int i = 0; i < 4; i++) nxt[i] -= 128;
`else
        for (int i = 0; i < 4; i++) if (nxt[i] > 255) nxt[i] = 255;
`endif
        best = 0;
        for (int i = 1; i < 4; i++) if (nxt[i] < nxt[best]) best = i;
        w.st = 2'(best);
        w.m = 8'(nxt[best]);
        w.eof = eof;
        ref_pm = nxt;
        ref_run = !eof;
        exp_q.push_back(w);
    endtask

    task automatic check_word();
        word_t w;
        chk("word_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
            w = exp_q.pop_front();
            chk("decisions", 32'(bus.decisions), 32'(w.dec));
            chk("best_state", 32'(bus.best_state), 32'(w.st));
            chk("best_metric", 32'(bus.best_metric), 32'(w.m));
            chk("dec_eof", 32'(bus.dec_eof), 32'(w.eof));
        end
        last_dec = bus.decisions;
        last_state = bus.best_state;
        last_metric = bus.best_metric;
        last_eof = bus.dec_eof;
        n_words++;
    endtask

    task automatic tick();
        @(negedge clk);
        acc = bus.rx_valid && bus.rx_ready;
        if (bus.dec_valid && bus.dec_ready) check_word();
        if (acc) model_push(bus.rx_sym, bus.rx_sof, bus.rx_eof);
        @(posedge clk);
        #1;
    endtask

    task automatic send(logic [1:0] sym, logic sof, logic eof);
        bit done;
        done = 0;
        bus.rx_valid = 1'b1;
        bus.rx_sym = sym;
        bus.rx_sof = sof;
        bus.rx_eof = eof;
        for (int i = 0; i < 50 && !done; i++) begin
            if (rnd_ready) bus.dec_ready = ($urandom_range(0, 3) != 0);
            tick();
            done = acc;
        end
        chk("rx_accepted", 32'(done), 1);
        bus.rx_valid = 1'b0;
        bus.rx_sof = 1'b0;
        bus.rx_eof = 1'b0;
    endtask

    task automatic flush();
        bus.rx_valid = 1'b0;
        bus.dec_ready = 1'b1;
        for (int i = 0; i < 20 && (exp_q.size() > 0 || bus.dec_valid); i++) tick();
        chk("flush_empty", 32'(exp_q.size()), 0);
        chk("flush_idle_valid", 32'(bus.dec_valid), 0);
    endtask

    initial begin
        n_checks = 0;
        n_pass = 0;
        rnd_ready = 0;
        ref_run = 0;
        rst = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_sym = 2'b00;
        bus.rx_sof = 1'b0;
        bus.rx_eof = 1'b0;
        bus.dec_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dec_valid", 32'(bus.dec_valid), 0);
        chk("rst_rx_ready", 32'(bus.rx_ready), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_decisions", 32'(bus.decisions), 0);
        chk("rst_best_metric", 32'(bus.best_metric), 0);
        chk("rst_best_state", 32'(bus.best_state), 0);
        chk("rst_dec_eof", 32'(bus.dec_eof), 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Clean frame: input bits 1,0,1,1 from state 0
        n_words = 0;
        send(2'b11, 1, 0);
        chk("clean_busy", 32'(busy), 1);
        send(2'b10, 0, 0);
        send(2'b00, 0, 0);
        send(2'b01, 0, 1);
        flush();
        chk("clean_words", 32'(n_words), 4);
        chk("clean_state", 32'(last_state), 3);
        chk("clean_metric", 32'(last_metric), 0);
        chk("clean_eof", 32'(last_eof), 1);
        chk("clean_busy_end", 32'(busy), 0);

        // Single bit error on symbol 2
        n_words = 0;
        send(2'b11, 1, 0);
        send(2'b11, 0, 0);
        send(2'b00, 0, 0);
        send(2'b01, 0, 1);
        flush();
        chk("err_words", 32'(n_words), 4);
        chk("err_state", 32'(last_state), 3);
        chk("err_metric", 32'(last_metric), 1);
        chk("err_eof", 32'(last_eof), 1);

        // Backpressure after word 1
        n_words = 0;
        send(2'b11, 1, 0);
        bus.dec_ready = 1'b0;
        bus.rx_valid = 1'b1;
        bus.rx_sym = 2'b10;
        snap_dec = bus.decisions;
        snap_state = bus.best_state;
        snap_metric = bus.best_metric;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_rx_ready", 32'(bus.rx_ready), 0);
            chk("bp_dec_valid", 32'(bus.dec_valid), 1);
            chk("bp_decisions", 32'(bus.decisions), 32'(snap_dec));
            chk("bp_state", 32'(bus.best_state), 32'(snap_state));
            chk("bp_metric", 32'(bus.best_metric), 32'(snap_metric));
        end
        bus.dec_ready = 1'b1;
        send(2'b10, 0, 0);
        send(2'b00, 0, 0);
        send(2'b01, 0, 1);
        flush();
        chk("bp_words", 32'(n_words), 4);
        chk("bp_final_state", 32'(last_state), 3);
        chk("bp_final_metric", 32'(last_metric), 0);

        // Long noisy frame exercising saturation or normalization
        send(2'b11, 1, 0);
        for (int i = 1; i < 200; i++) send((i % 2) ? 2'b10 : 2'b11, 0, i == 199);
        flush();

        // Random symbols, frame markers and backpressure
        rnd_ready = 1;
        for (int i = 0; i < 400; i++)
            send(2'($urandom_range(0, 3)), $urandom_range(0, 49) == 0, $urandom_range(0, 49) == 0);
        rnd_ready = 0;
        flush();

        // Asynchronous reset while word 2 is pending
        n_words = 0;
        send(2'b11, 1, 0);
        send(2'b10, 0, 0);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_dec_valid", 32'(bus.dec_valid), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_metric", 32'(bus.best_metric), 0);
        exp_q.delete();
        ref_run = 0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_words = 0;
        send(2'b00, 0, 1);
        flush();
        chk("post_rst_words", 32'(n_words), 1);
        chk("post_rst_state", 32'(last_state), 0);
        chk("post_rst_metric", 32'(last_metric), 0);

        // sof and eof on a single symbol
        n_words = 0;
        send(2'b00, 1, 1);
        chk("single_busy", 32'(busy), 0);
        flush();
        chk("single_words", 32'(n_words), 1);
        chk("single_decisions", 32'(last_dec), 0);
        chk("single_state", 32'(last_state), 0);
        chk("single_metric", 32'(last_metric), 0);
        chk("single_eof", 32'(last_eof), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
